afu_mmio: RTL and testbench

MMIO responder for the CAPI AFU. It sits between the PSL MMIO interface and the AFU top level and serves two spaces. AFU descriptor reads (ha_mmcfg=1) return the fixed descriptor the PSL needs to bring the AFU up in dedicated-process mode. Problem-space accesses (ha_mmcfg=0) hit a small read/write scratch register file. Every request is acknowledged with a fixed two-cycle latency and odd-parity read data.

---
 rtl/afu_pkg.sv | 41 ++++
 rtl/afu_mmio_if.sv | 32 +++
 rtl/shift_register.sv | 35 +++
 rtl/afu_mmio.sv | 149 ++++++++++++++
 tb/tb_afu_mmio.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/afu_pkg.sv
// afu_pkg: shared definitions for the AFU MMIO slice.
//   - MMIO field widths (word address 24 bits, data 64 bits)
//   - default AFU descriptor word 0
//   - request/response records carried between pipeline stages
//   - odd-parity helpers (parity bit that makes the total count of ones odd)
package afu_pkg;

    localparam int MMIO_AD_W   = 24;
    localparam int MMIO_DATA_W = 64;

    // 0 interrupts, 1 process, 0 CRs, programming model 0x8010 (dedicated process)
    localparam logic [63:0] DESC_WORD0_DEF = 64'h0000_0001_0000_8010;

    // Captured request; vectors are numeric (bit 0 = LSB), unlike the PSL bus order.
    typedef struct packed {
        logic                   val;
        logic                   cfg;
        logic                   rnw;
        logic                   dw;
        logic [MMIO_AD_W-1:0]   ad;
        logic [MMIO_DATA_W-1:0] data;
        logic                   ad_ok;
        logic                   data_ok;
    } mmio_req_t;

    // Response word as it travels through the output delay stage.
    typedef struct packed {
        logic                   ack;
        logic [MMIO_DATA_W-1:0] data;
        logic                   par;
    } mmio_resp_t;

    function automatic logic odd_par24(input logic [MMIO_AD_W-1:0] v);
        return ~^v;
    endfunction

    function automatic logic odd_par64(input logic [MMIO_DATA_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/afu_mmio_if.sv
// afu_mmio_if: PSL <-> AFU MMIO bus.
//   ha_* : request from the PSL (valid, space, direction, size, address, data, parities)
//   ah_* : response from the AFU (ack pulse, read data, read-data parity)
// Buses use PSL bit order: bit 0 is the MSB.
interface afu_mmio_if;
    import afu_pkg::*;

    logic        ha_mmval;
    logic        ha_mmcfg;
    logic        ha_mmrnw;
    logic        ha_mmdw;
    logic [0:23] ha_mmad;
    logic        ha_mmadpar;
    logic [0:63] ha_mmdata;
    logic        ha_mmdatapar;
    logic        ah_mmack_out;
    logic [0:63] ah_mmdata_out;
    logic        ah_mmdatapar;

    modport master (
        output ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar,
               ha_mmdata, ha_mmdatapar,
        input  ah_mmack_out, ah_mmdata_out, ah_mmdatapar
    );

    modport slave (
        input  ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar,
               ha_mmdata, ha_mmdatapar,
        output ah_mmack_out, ah_mmdata_out, ah_mmdatapar
    );

endinterface

// File: rtl/shift_register.sv
// shift_register: DEPTH-stage delay line of WIDTH-bit words.
//   clock : rising-edge clock
//   reset : asynchronous, active-low; loads every stage with RST_VAL
//   in    : word entering the line
//   out   : word leaving the line DEPTH cycles later
module shift_register #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Delay line: stage 0 takes the input, each later stage takes its predecessor.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out = stage_r[DEPTH-1];

endmodule

// File: rtl/afu_mmio.sv
// afu_mmio: MMIO responder for a CAPI AFU.
//   ha_pclock  : clock
//   ha_reset_n : asynchronous active-low reset
//   mmio       : PSL MMIO bus (slave side)
// Descriptor space (ha_mmcfg=1) returns DESC_WORD0 at doubleword 0 and zero
// elsewhere; problem space hits NUM_REGS 64-bit scratch registers. Every
// request is acked exactly once, two edges after it is sampled.
module afu_mmio
    import afu_pkg::*;
#(
    parameter logic [63:0] DESC_WORD0 = DESC_WORD0_DEF,
    parameter int          NUM_REGS   = 4
) (
    input  logic     ha_pclock,
    input  logic     ha_reset_n,
    afu_mmio_if.slave mmio
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam mmio_resp_t RESP_IDLE = '{ack: 1'b0, data: 64'h0, par: 1'b1};

    mmio_req_t         req_s;
    mmio_req_t         req_r;
    mmio_resp_t        resp_s;
    mmio_resp_t        resp_r;
    logic [65:0]       sr_out_s;
    logic [63:0]       regs_r [NUM_REGS];
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              half_s;
    logic [63:0]       rd_dword_s;
    logic [63:0]       rd_data_s;
    logic              wr_en_s;

    // Flatten the bus into a numeric-order request and check its parities.
    always_comb begin
        req_s         = '0;
        req_s.val     = mmio.ha_mmval;
        req_s.cfg     = mmio.ha_mmcfg;
        req_s.rnw     = mmio.ha_mmrnw;
        req_s.dw      = mmio.ha_mmdw;
        req_s.ad      = mmio.ha_mmad;
        req_s.data    = mmio.ha_mmdata;
        req_s.ad_ok   = (odd_par24(mmio.ha_mmad) == mmio.ha_mmadpar);
        req_s.data_ok = (odd_par64(mmio.ha_mmdata) == mmio.ha_mmdatapar);
    end

    // Request capture stage (edge T).
    always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
        if (!ha_reset_n) begin
            req_r <= '0;
        end else begin
            req_r <= req_s;
        end
    end

    // Address decode: bit 0 picks the word half, the next IDX_W bits pick the
    // register, anything above must be zero for problem space.
    always_comb begin
        half_s     = req_r.ad[0];
        idx_s      = req_r.ad[IDX_W:1];
        in_range_s = ~|req_r.ad[MMIO_AD_W-1:IDX_W+1];
    end

    // Read data selection and response formation.
    always_comb begin
        rd_dword_s = 64'h0;
        rd_data_s  = 64'h0;
        resp_s     = RESP_IDLE;
        if (req_r.cfg) begin
            if (req_r.ad[MMIO_AD_W-1:1] == 23'h0) begin
                rd_dword_s = DESC_WORD0;
            end else begin
                rd_dword_s = 64'h0;
            end
        end else if (in_range_s) begin
            rd_dword_s = regs_r[idx_s];
        end else begin
            rd_dword_s = 64'h0;
        end
        // Word reads replicate the selected half; bus half [0:31] is numeric [63:32].
        if (req_r.dw) begin
            rd_data_s = rd_dword_s;
        end else if (half_s) begin
            rd_data_s = {rd_dword_s[31:0], rd_dword_s[31:0]};
        end else begin
            rd_data_s = {rd_dword_s[63:32], rd_dword_s[63:32]};
        end
        if (req_r.val) begin
            resp_s.ack  = 1'b1;
            resp_s.data = req_r.rnw ? rd_data_s : 64'h0;
            resp_s.par  = odd_par64(resp_s.data);
        end else begin
            resp_s = RESP_IDLE;
        end
    end

    // Writes land only for in-range problem-space requests with clean parity.
    always_comb begin
        wr_en_s = req_r.val & ~req_r.rnw & ~req_r.cfg & in_range_s
                & req_r.ad_ok & req_r.data_ok;
    end

    // Scratch register file; word writes always source bus bits [32:63].
    always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
        if (!ha_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 64'h0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (idx_s == IDX_W'(i))) begin
                    if (req_r.dw) begin
                        regs_r[i] <= req_r.data;
                    end else if (half_s) begin
                        regs_r[i][31:0] <= req_r.data[31:0];
                    end else begin
                        regs_r[i][63:32] <= req_r.data[31:0];
                    end
                end
            end
        end
    end

    // Response register stage (edge T+1).
    always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
        if (!ha_reset_n) begin
            resp_r <= RESP_IDLE;
        end else begin
            resp_r <= resp_s;
        end
    end

    shift_register #(
        .WIDTH   (66),
        .DEPTH   (1),
        .RST_VAL (66'h0_0000_0000_0000_0001)
    ) u_out_sr (
        .clock (ha_pclock),
        .reset (ha_reset_n),
        .in    (resp_r),
        .out   (sr_out_s)
    );

    assign mmio.ah_mmack_out  = sr_out_s[65];
    assign mmio.ah_mmdata_out = sr_out_s[64:1];
    assign mmio.ah_mmdatapar  = sr_out_s[0];

endmodule

// File: tb/tb_afu_mmio.sv
// tb_afu_mmio: directed self-checking bench for afu_mmio.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_afu_mmio;
    import afu_pkg::*;

    logic ha_pclock;
    logic ha_reset_n;
    int   n_cmp;
    int   n_bad;

    afu_mmio_if mmio ();

    afu_mmio #(
        .DESC_WORD0 (64'h0000_0001_0000_8010),
        .NUM_REGS   (4)
    ) dut (
        .ha_pclock  (ha_pclock),
        .ha_reset_n (ha_reset_n),
        .mmio       (mmio)
    );

    initial ha_pclock = 1'b0;
    always #5 ha_pclock = ~ha_pclock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ack, input logic [63:0] data, input logic par);
        chk({tag, ".ack"},  {63'h0, mmio.ah_mmack_out}, {63'h0, ack});
        chk({tag, ".data"}, mmio.ah_mmdata_out, data);
        chk({tag, ".par"},  {63'h0, mmio.ah_mmdatapar}, {63'h0, par});
    endtask

    task automatic issue(input logic cfg, input logic rnw, input logic dw, input logic [23:0] ad,
                         input logic [63:0] data, input logic bad_a, input logic bad_d);
        mmio.ha_mmval     = 1'b1;
        mmio.ha_mmcfg     = cfg;
        mmio.ha_mmrnw     = rnw;
        mmio.ha_mmdw      = dw;
        mmio.ha_mmad      = ad;
        mmio.ha_mmadpar   = (~^ad) ^ bad_a;
        mmio.ha_mmdata    = data;
        mmio.ha_mmdatapar = (~^data) ^ bad_d;
    endtask

    task automatic idle();
        mmio.ha_mmval = 1'b0;
    endtask

    // One isolated request: no ack after T+1, ack after T+2, quiet after T+3.
    task automatic txn(input string tag, input logic cfg, input logic rnw, input logic dw,
                       input logic [23:0] ad, input logic [63:0] data, input logic bad_a,
                       input logic bad_d, input logic [63:0] exp_d, input logic exp_p);
        @(negedge ha_pclock);
        issue(cfg, rnw, dw, ad, data, bad_a, bad_d);
        @(negedge ha_pclock);
        idle();
        @(negedge ha_pclock);
        chk({tag, ".early"}, {63'h0, mmio.ah_mmack_out}, 64'h0);
        @(negedge ha_pclock);
        chk_out(tag, 1'b1, exp_d, exp_p);
        @(negedge ha_pclock);
        chk_out({tag, ".after"}, 1'b0, 64'h0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ha_reset_n        = 1'b0;
        mmio.ha_mmval     = 1'b0;
        mmio.ha_mmcfg     = 1'b0;
        mmio.ha_mmrnw     = 1'b1;
        mmio.ha_mmdw      = 1'b1;
        mmio.ha_mmad      = 24'h0;
        mmio.ha_mmadpar   = 1'b1;
        mmio.ha_mmdata    = 64'h0;
        mmio.ha_mmdatapar = 1'b1;
        repeat (3) @(negedge ha_pclock);
        ha_reset_n = 1'b1;
        @(negedge ha_pclock);
        chk_out("reset", 1'b0, 64'h0, 1'b1);

        // Descriptor space
        txn("desc_rd0", 1'b1, 1'b1, 1'b1, 24'h0, 64'h0, 1'b0, 1'b0, 64'h0000_0001_0000_8010, 1'b0);
        txn("desc_rd2", 1'b1, 1'b1, 1'b1, 24'h2, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("desc_wr0", 1'b1, 1'b0, 1'b1, 24'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("desc_rd0b", 1'b1, 1'b1, 1'b1, 24'h0, 64'h0, 1'b0, 1'b0, 64'h0000_0001_0000_8010, 1'b0);

        // Problem space doubleword and word accesses
        txn("wr_dw4", 1'b0, 1'b0, 1'b1, 24'h4, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rd_dw4", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
        txn("wr_w5", 1'b0, 1'b0, 1'b0, 24'h5, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rd_dw4b", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0123_4567_DEAD_BEEF, 1'b1);
        txn("rd_w4", 1'b0, 1'b1, 1'b0, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0123_4567_0123_4567, 1'b1);
        txn("rd_w5", 1'b0, 1'b1, 1'b0, 24'h5, 64'h0, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        txn("wr_w4", 1'b0, 1'b0, 1'b0, 24'h6, 64'h0000_0000_0000_0007, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rd_dw6", 1'b0, 1'b1, 1'b1, 24'h6, 64'h0, 1'b0, 1'b0, 64'h0000_0007_0000_0000, 1'b0);

        // Parity-corrupted and out-of-range writes are acked but dropped
        txn("wr_baddp", 1'b0, 1'b0, 1'b1, 24'h4, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 64'h0, 1'b1);
        txn("rd_baddp", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0123_4567_DEAD_BEEF, 1'b1);
        txn("wr_badap", 1'b0, 1'b0, 1'b1, 24'h4, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, 64'h0, 1'b1);
        txn("rd_badap", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b1, 1'b0, 64'h0123_4567_DEAD_BEEF, 1'b1);
        txn("wr_oor", 1'b0, 1'b0, 1'b1, 24'h104, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rd_oor_alias", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0123_4567_DEAD_BEEF, 1'b1);
        txn("rd_oor", 1'b0, 1'b1, 1'b1, 24'h8, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Write at T visible to read sampled at T+1
        @(negedge ha_pclock);
        issue(1'b0, 1'b0, 1'b1, 24'h2, 64'h0000_0000_0000_0007, 1'b0, 1'b0);
        @(negedge ha_pclock);
        issue(1'b0, 1'b1, 1'b1, 24'h2, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        idle();
        @(negedge ha_pclock);
        chk_out("raw.wr", 1'b1, 64'h0, 1'b1);
        @(negedge ha_pclock);
        chk_out("raw.rd", 1'b1, 64'h0000_0000_0000_0007, 1'b0);
        @(negedge ha_pclock);
        chk_out("raw.after", 1'b0, 64'h0, 1'b1);

        // Three back-to-back reads give three consecutive in-order acks
        @(negedge ha_pclock);
        issue(1'b1, 1'b1, 1'b1, 24'h0, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        issue(1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        issue(1'b0, 1'b1, 1'b1, 24'h2, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        idle();
        chk_out("b2b.0", 1'b1, 64'h0000_0001_0000_8010, 1'b0);
        @(negedge ha_pclock);
        chk_out("b2b.1", 1'b1, 64'h0123_4567_DEAD_BEEF, 1'b1);
        @(negedge ha_pclock);
        chk_out("b2b.2", 1'b1, 64'h0000_0000_0000_0007, 1'b0);
        @(negedge ha_pclock);
        chk_out("b2b.after", 1'b0, 64'h0, 1'b1);

        // Reset with one request acked and one still in flight
        @(negedge ha_pclock);
        issue(1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        issue(1'b1, 1'b1, 1'b1, 24'h0, 64'h0, 1'b0, 1'b0);
        @(negedge ha_pclock);
        idle();
        @(negedge ha_pclock);
        chk_out("rst.pre", 1'b1, 64'h0123_4567_DEAD_BEEF, 1'b1);
        ha_reset_n = 1'b0;
        #1;
        chk_out("rst.now", 1'b0, 64'h0, 1'b1);
        @(negedge ha_pclock);
        ha_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ha_pclock);
            chk({"rst.noack", 8'(8'h30 + i)}, {63'h0, mmio.ah_mmack_out}, 64'h0);
        end

        // First request after release is accepted; all scratch registers cleared
        txn("rst.rd0", 1'b0, 1'b1, 1'b1, 24'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rst.rd2", 1'b0, 1'b1, 1'b1, 24'h2, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rst.rd4", 1'b0, 1'b1, 1'b1, 24'h4, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        txn("rst.rd6", 1'b0, 1'b1, 1'b1, 24'h6, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
